// File: rtl/mem_access_unit.sv
// Sequential load/store memory access unit: direct and indirect (pointer-fetch) accesses
// over a ready-handshaked data-memory bus, with an optional wait-state timeout.
module mem_access_unit #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_indirect,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic          mem_en,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IND_RD = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          op_write, op_write_nxt;
  logic [DW-1:0] op_wdata, op_wdata_nxt;
  logic          mem_en_nxt, mem_rd_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_din_nxt;
  logic          resp_valid_nxt, resp_err_nxt;
  logic [DW-1:0] resp_rdata_nxt;
  logic          timeout_hit;

  assign req_ready   = (state == S_IDLE);
  assign timeout_hit = TO_EN && (wait_cnt == CNT_LAST);

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      op_write   <= 1'b0;
      op_wdata   <= '0;
      mem_en     <= 1'b0;
      mem_rd     <= 1'b1;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      op_write   <= op_write_nxt;
      op_wdata   <= op_wdata_nxt;
      mem_en     <= mem_en_nxt;
      mem_rd     <= mem_rd_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_din    <= mem_din_nxt;
      resp_valid <= resp_valid_nxt;
      resp_err   <= resp_err_nxt;
      resp_rdata <= resp_rdata_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    op_write_nxt   = op_write;
    op_wdata_nxt   = op_wdata;
    mem_en_nxt     = mem_en;
    mem_rd_nxt     = mem_rd;
    mem_addr_nxt   = mem_addr;
    mem_din_nxt    = mem_din;
    resp_valid_nxt = 1'b0;
    resp_err_nxt   = 1'b0;
    resp_rdata_nxt = resp_rdata;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_write_nxt = req_write;
          op_wdata_nxt = req_wdata;
          wait_cnt_nxt = '0;
          mem_en_nxt   = 1'b1;
          mem_addr_nxt = req_addr;
          if (req_indirect) begin
            state_nxt   = S_IND_RD;
            mem_rd_nxt  = 1'b1;
            mem_din_nxt = '0;
          end else begin
            state_nxt   = S_ACCESS;
            mem_rd_nxt  = ~req_write;
            mem_din_nxt = req_write ? req_wdata : '0;
          end
        end
      end
      S_IND_RD: begin
        if (mem_ready) begin
          state_nxt    = S_ACCESS;
          wait_cnt_nxt = '0;
          mem_addr_nxt = mem_dout[AW-1:0];
          mem_rd_nxt   = ~op_write;
          mem_din_nxt  = op_write ? op_wdata : '0;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          state_nxt      = S_IDLE;
          wait_cnt_nxt   = '0;
          mem_en_nxt     = 1'b0;
          mem_rd_nxt     = 1'b1;
          mem_addr_nxt   = '0;
          mem_din_nxt    = '0;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = op_write ? '0 : mem_dout;
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        wait_cnt_nxt = '0;
        mem_en_nxt   = 1'b0;
        mem_rd_nxt   = 1'b1;
        mem_addr_nxt = '0;
        mem_din_nxt  = '0;
      end
    endcase

    // Wait-state handling for both bus phases; a ready edge always takes priority
    if ((state == S_IND_RD || state == S_ACCESS) && !mem_ready) begin
      if (timeout_hit) begin
        state_nxt      = S_IDLE;
        wait_cnt_nxt   = '0;
        mem_en_nxt     = 1'b0;
        mem_rd_nxt     = 1'b1;
        mem_addr_nxt   = '0;
        mem_din_nxt    = '0;
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b1;
        resp_rdata_nxt = '0;
      end else if (wait_cnt != CNT_MAX) begin
        wait_cnt_nxt = wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised, sequential successor to the LC-3 memory access stage. It accepts one load/store request at a time (direct or indirect), sequences the data-memory bus through a small FSM, and tolerates variable memory wait-states via a ready handshake. A wait-state timeout returns an error response. The bus is always driven, never tri-stated. It sits between the execute/writeback control and the data memory.

Parameters:
DW, 16, data width (DW >= AW required)
AW, 16, address width
TIMEOUT, 15, max consecutive not-ready cycles per bus phase before abort; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit idle, can accept
req_write  in  1  1=store (ST/STR/STI), 0=load (LD/LDR/LDI)
req_indirect  in  1  1=LDI/STI (pointer fetch first)
req_addr  in  AW  effective address (pointer address if indirect)
req_wdata  in  DW  store data
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: timeout abort
resp_rdata  out  DW  load data (0 for stores/errors)
mem_en  out  1  bus cycle active
mem_rd  out  1  1=read, 0=write
mem_addr  out  AW  memory address
mem_din  out  DW  write data to memory
mem_dout  in  DW  read data from memory
mem_ready  in  1  memory completes current phase this cycle

Behaviour:
- States: IDLE, IND_RD, ACCESS. req_ready = (state==IDLE), combinational.
- Reset (async, reset=0): state IDLE; mem_en=0, mem_rd=1, mem_addr=0, mem_din=0, resp_valid=0, resp_err=0, resp_rdata=0, wait counter=0. Reset mid-operation aborts silently: no response.
- All outputs except req_ready are registered.
- Accept: at edge with req_valid && req_ready, latch write/indirect/wdata, then:
  - indirect=1: go to IND_RD with mem_en=1, mem_rd=1, mem_addr=req_addr, mem_din=0.
  - indirect=0: go to ACCESS with mem_en=1, mem_rd=~req_write, mem_addr=req_addr, mem_din=(write ? req_wdata : 0).
- req_valid while req_ready=0 is ignored. Requester holds it until accepted.
- IND_RD, edge with mem_ready=1: pointer = mem_dout[AW-1:0]. Go to ACCESS with mem_addr=pointer, mem_rd=~write, mem_din=(write ? wdata : 0). Counter cleared.
- ACCESS, edge with mem_ready=1: go to IDLE; mem_en=0, mem_rd=1, mem_addr=0, mem_din=0. resp_valid=1 and resp_err=0 for exactly one cycle. resp_rdata=mem_dout for a load, 0 for a store.
- resp_rdata holds its value until the next response.
- Wait counter:
  - Increments on each edge in IND_RD/ACCESS with mem_ready=0; cleared on phase change.
  - If TIMEOUT>0, mem_ready=0 and counter==TIMEOUT-1: abort to IDLE. Bus idled as above; resp_valid=1, resp_err=1, resp_rdata=0.
  - mem_ready=1 on the timeout edge completes normally, because ready wins.
  - Counter width is $clog2(TIMEOUT+1), minimum 1. It never wraps.
- Latency, accept edge to resp_valid high, zero wait-states: direct 1 cycle, indirect 2 cycles. Each wait-state adds 1 cycle.
- Back-to-back: req_ready rises in the same cycle resp_valid is high. A new request can be accepted at the next edge, giving 1 idle bus cycle between operations.
- mem_ready is ignored in IDLE.

Test Plan:
- Reset mid-op: assert reset=0 during IND_RD -> all outputs return to reset values immediately; no resp_valid pulse follows.
- LD, zero wait: req addr=0x3000, mem_ready=1, mem_dout=0xBEEF -> mem_en=1, mem_rd=1, mem_addr=0x3000 for 1 cycle; next cycle resp_valid=1, resp_rdata=0xBEEF, resp_err=0.
- STI, 2 wait-states per phase: addr=0x4000, wdata=0x1234, pointer word=0x5005 -> read at 0x4000 held 3 cycles, then write mem_rd=0, mem_addr=0x5005, mem_din=0x1234 held 3 cycles; resp_valid 6 cycles after accept, resp_rdata=0.
- Timeout: TIMEOUT=15, mem_ready stuck 0 on a LD -> after 15 cycles resp_valid=1, resp_err=1, resp_rdata=0, mem_en=0, req_ready=1.
- Ready on timeout edge: mem_ready=1 on the 15th wait cycle -> normal response, resp_err=0.
- Busy ignore and back-to-back: second req_valid held during LDR -> not accepted until req_ready=1; accepted on the edge after resp_valid; exactly one idle bus cycle between operations.
